// File: rtl/reg_share_arb_pkg.sv
// rtl/reg_share_arb_pkg.sv - shared types and round-robin selection for reg_share_arb
package reg_share_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      DONE   = 2'd2,
      LOCKED = 2'd3
   } state_e;

   localparam int MAX_REQ = 8;

   // Returns {valid, index}: first set req at or after ptr, wrapping modulo n.
   function automatic logic [3:0] rr_select(input logic [MAX_REQ-1:0] req,
                                            input logic [2:0]         ptr,
                                            input int                 n);
      logic [3:0] res;
      int         idx;
      res = '0;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         if (k < n) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if (req[idx]) res = {1'b1, idx[2:0]};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/reg_share_arb_if.sv
// rtl/reg_share_arb_if.sv - requester and register-bank signals of reg_share_arb
interface reg_share_arb_if #(
   parameter int N_REQ = 4,
   parameter int DW    = 8
);
   logic [N_REQ-1:0]    req;
   logic [N_REQ-1:0]    clr;
   logic [N_REQ-1:0]    lock;
   logic [N_REQ*DW-1:0] wdata;
   logic [N_REQ-1:0]    gnt;
   logic [N_REQ-1:0]    ack;
   logic                reg_en_n;
   logic                reg_clr_n;
   logic [DW-1:0]       reg_din;
   logic                busy;

   modport master (
      output req, clr, lock, wdata,
      input  gnt, ack, reg_en_n, reg_clr_n, reg_din, busy
   );

   modport slave (
      input  req, clr, lock, wdata,
      output gnt, ack, reg_en_n, reg_clr_n, reg_din, busy
   );
endinterface

// File: rtl/reg_share_arb_rr_pick.sv
// rtl/reg_share_arb_rr_pick.sv - combinational round-robin winner selection
module rr_pick
   import reg_share_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic             valid_o,
   output logic [PTR_W-1:0] win_o
);
   logic [MAX_REQ-1:0] req_ext;
   logic [2:0]         ptr_ext;
   logic [3:0]         sel;
   logic               unused_sel;

   always_comb begin
      req_ext              = '0;
      req_ext[N_REQ-1:0]   = req_i;
      ptr_ext              = '0;
      ptr_ext[PTR_W-1:0]   = ptr_i;
      sel                  = rr_select(req_ext, ptr_ext, N_REQ);
   end

   assign valid_o    = sel[3];
   assign win_o      = sel[PTR_W-1:0];
   assign unused_sel = ^sel[2:0];
endmodule

// File: rtl/reg_share_arb.sv
// rtl/reg_share_arb.sv - round-robin arbiter/sequencer sharing one register bank
module reg_share_arb
   import reg_share_pkg::*;
#(
   parameter  int N_REQ = 4,
   parameter  int DW    = 8,
   localparam int PTR_W = $clog2(N_REQ)
) (
   input logic            clk,
   input logic            rst_n,
   reg_share_arb_if.slave bus
);
   state_e           state_q;
   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] own_q;
   logic [PTR_W-1:0] ptr_d;
   logic [PTR_W-1:0] pick_w;
   logic             pick_valid;
   logic [N_REQ-1:0] gnt_q;
   logic [N_REQ-1:0] ack_q;
   logic             reg_en_n_q;
   logic             reg_clr_n_q;
   logic [DW-1:0]    reg_din_q;
   logic             busy_q;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req_i   (bus.req),
      .ptr_i   (ptr_q),
      .valid_o (pick_valid),
      .win_o   (pick_w)
   );

   assign ptr_d = (own_q == PTR_W'(N_REQ - 1)) ? '0 : own_q + PTR_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         own_q       <= '0;
         gnt_q       <= '0;
         ack_q       <= '0;
         reg_en_n_q  <= 1'b1;
         reg_clr_n_q <= 1'b1;
         reg_din_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  state_q     <= WRITE;
                  own_q       <= pick_w;
                  gnt_q       <= N_REQ'(1) << pick_w;
                  reg_en_n_q  <= 1'b0;
                  busy_q      <= 1'b1;
                  reg_clr_n_q <= !bus.clr[pick_w];
                  reg_din_q   <= bus.clr[pick_w] ? '0 : bus.wdata[pick_w*DW +: DW];
               end
            end
            // The bank captures on this edge; req dropping now does not matter.
            WRITE: begin
               state_q     <= DONE;
               reg_en_n_q  <= 1'b1;
               reg_clr_n_q <= 1'b1;
               ack_q       <= gnt_q;
            end
            DONE: begin
               ack_q <= '0;
               if (bus.lock[own_q]) begin
                  state_q <= LOCKED;
               end else begin
                  state_q <= IDLE;
                  ptr_q   <= ptr_d;
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
               end
            end
            LOCKED: begin
               // Releasing the lock wins over a pending request from the owner.
               if (!bus.lock[own_q]) begin
                  state_q <= IDLE;
                  ptr_q   <= ptr_d;
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (bus.req[own_q]) begin
                  state_q     <= WRITE;
                  reg_en_n_q  <= 1'b0;
                  reg_clr_n_q <= !bus.clr[own_q];
                  reg_din_q   <= bus.clr[own_q] ? '0 : bus.wdata[own_q*DW +: DW];
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.ack       = ack_q;
   assign bus.reg_en_n  = reg_en_n_q;
   assign bus.reg_clr_n = reg_clr_n_q;
   assign bus.reg_din   = reg_din_q;
   assign bus.busy      = busy_q;
endmodule

// File: doc/reg_share_arb.md
Name: reg_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one DW-bit register bank among N_REQ requesters.
- The register bank is built from the team's synchronous-clear, active-low-enable D flip-flop cells.
- Drives the bank's active-low write enable, synchronous clear and data input.
- Returns a one-cycle ack to the winning requester and supports a lock for back-to-back exclusive writes.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DW, 8, register data width
- PTR_W, $clog2(N_REQ), round-robin pointer width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  write request per requester; held until ack
- clr  in  N_REQ  with req: request a synchronous clear instead of a data write
- lock  in  N_REQ  keep the grant after the current write
- wdata  in  N_REQ*DW  packed write data; requester i occupies bits [i*DW +: DW]
- gnt  out  N_REQ  one-hot current owner, or zero
- ack  out  N_REQ  one-cycle pulse: owner's write has been committed
- reg_en_n  out  1  active-low enable to the register bank
- reg_clr_n  out  1  active-low synchronous clear to the register bank
- reg_din  out  DW  data to the register bank
- busy  out  1  high when state != IDLE

Behaviour:
- All outputs are registered. On rst_n low, immediately:
  - state=IDLE, ptr=0
  - gnt=0, ack=0
  - reg_en_n=1, reg_clr_n=1, reg_din=0, busy=0
- A reset during WRITE abandons that write; reg_en_n returns high asynchronously.
- FSM states: IDLE, WRITE, DONE, LOCKED.
- IDLE:
  - If |req, pick winner w = first set req index at or after ptr, wrapping modulo N_REQ.
  - Next edge: state=WRITE, gnt=onehot(w), reg_en_n=0.
  - If clr[w]: reg_clr_n=0 and reg_din=0; else reg_clr_n=1 and reg_din=wdata[w].
  - No req: stay in IDLE, all outputs idle.
- WRITE (exactly 1 cycle): the bank captures on the edge that leaves WRITE.
  - Next: state=DONE, reg_en_n=1, reg_clr_n=1, ack[w]=1.
  - req[w] dropping during WRITE is ignored; the write completes.
- DONE (1 cycle): ack[w] is high during this cycle only; gnt[w] stays high.
  - lock[w]=1: next LOCKED.
  - Else: ptr=(w+1) mod N_REQ, gnt=0, next IDLE.
- LOCKED: gnt[w] held; all other req ignored.
  - lock[w]=0: ptr=(w+1) mod N_REQ, gnt=0, next IDLE (takes priority over req[w]).
  - Else if req[w]=1: reload reg_din / reg_clr_n from requester w, reg_en_n=0, next WRITE.
  - Else: stay in LOCKED.
- Latency:
  - Request sampled at edge E0 -> reg_en_n low after E0 -> bank commit at E1 -> ack high after E1, low after E2.
  - Minimum unlocked spacing per requester is 3 cycles; locked back-to-back spacing is also 3 cycles.
- Requesters must deassert req in the cycle ack is seen, or a second write is issued.
- lock on a non-granted requester has no effect. lock sampled in IDLE has no effect until that requester wins.
- clr with req=0 is ignored.
- ptr wraps N_REQ-1 -> 0. For non-power-of-2 N_REQ, ptr never exceeds N_REQ-1.
- Fairness: with all req held high and lock low, grants rotate 0,1,...,N_REQ-1,0.
- Invariants:
  - gnt is one-hot or zero.
  - ack is a subset of gnt.
  - reg_en_n is low only in WRITE.

Decomposition:
- Package reg_share_pkg holds:
  - state typedef (IDLE=2'd0, WRITE=2'd1, DONE=2'd2, LOCKED=2'd3)
  - a function for round-robin index selection
- One sub-module rr_pick:
  - combinational; inputs req vector and ptr
  - outputs valid and winner index w
  - this is the only place the rotate/priority logic lives.

Test Plan:
1. Reset: rst_n low mid-WRITE (req[2]=1, wdata[2]=8'hA5) -> reg_en_n=1, gnt=0, ack=0 immediately; after release with req cleared, state=IDLE and busy=0.
2. Single write: req[1]=1, wdata[1]=8'h3C at E0 -> gnt=4'b0010 and reg_din=8'h3C after E0, reg_en_n=0 for exactly one cycle, ack[1] after E1; the bank holds 8'h3C.
3. Rotation: req=4'b1111 held, lock=0 -> ack order 0,1,2,3,0, each 3 cycles apart.
4. Clear: req[3]=1, clr[3]=1, bank preloaded with 8'hFF -> reg_clr_n=0 and reg_en_n=0 in WRITE; bank reads 8'h00; ack[3] pulses.
5. Lock: req[0]=1, lock[0]=1 with req[2]=1 pending; three writes from 0 (8'h11, 8'h22, 8'h33) -> gnt stays 4'b0001 and req[2] gets no grant. Drop lock[0] -> next grant to 2 (ptr=1, search 1,2).
6. Pending-requester clears lock: in LOCKED with req[0]=1, deassert lock[0] -> no WRITE issued, state=IDLE, then requester 0 re-arbitrates behind ptr=1.
